// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared width constant and FSM state encoding for the ECC datapath
//
// Purpose : common definitions for the ECC arithmetic blocks.
// Contents: ECC_W  - operand width (256)
//           STEP_W - internal intermediate width (ECC_W + 2)
//           state_e - two-state controller encoding {IDLE, RUN}
package ecc_pkg;

  localparam int ECC_W  = 256;
  localparam int STEP_W = ECC_W + 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mod_mul_step.sv
// rtl/mod_mul_step.sv - one MSB-first interleaved shift-add modular multiply iteration
//
// Purpose : r_out = (2*r_in mod m_in) [+ b_in if a_bit] mod m_in, purely combinational.
// Ports   : r_in   [ECC_W-1:0] in  - running remainder
//           b_in   [ECC_W-1:0] in  - multiplier operand
//           m_in   [ECC_W-1:0] in  - modulus
//           a_bit              in  - current multiplicand bit
//           r_out  [ECC_W-1:0] out - next remainder
module mod_mul_step
  import ecc_pkg::*;
(
  input  logic [ECC_W-1:0] r_in,
  input  logic [ECC_W-1:0] b_in,
  input  logic [ECC_W-1:0] m_in,
  input  logic             a_bit,
  output logic [ECC_W-1:0] r_out
);

  logic [STEP_W-1:0] m_ext;
  logic [STEP_W-1:0] dbl;
  logic [STEP_W-1:0] dbl_red;
  logic [STEP_W-1:0] sum;
  logic [STEP_W-1:0] sum_red;

  always_comb begin
    m_ext = {2'b00, m_in};

    // 2R < 2M, so a single conditional subtraction fully reduces it
    dbl = {1'b0, r_in, 1'b0};
    if (dbl >= m_ext) dbl_red = dbl - m_ext;
    else              dbl_red = dbl;

    // R + B < 2M for in-range operands, again one subtraction suffices
    sum = dbl_red + {2'b00, b_in};
    if (a_bit) begin
      if (sum >= m_ext) sum_red = sum - m_ext;
      else              sum_red = sum;
    end else begin
      sum_red = dbl_red;
    end

    // M = 0 is defined to give 0. Bits above ECC_W can only be set by
    // out-of-range operands, whose result is unspecified, so they also force 0.
    if ((m_in == '0) || (sum_red[STEP_W-1:ECC_W] != 2'b00)) r_out = '0;
    else                                                     r_out = sum_red[ECC_W-1:0];
  end

endmodule

// File: rtl/mod_mul.sv
// rtl/mod_mul.sv - sequential 256-bit modular multiplier, one operand bit per clock
//
// Purpose : out_data = (opA*opB) mod opM, 256 clocks after an accepted in_valid.
// Ports   : clk, rst (async active-high)
//           in_valid            in  - one-cycle start pulse, operands valid that cycle
//           opA, opB, opM [255] in  - multiplicand, multiplier, modulus
//           out_valid           out - one-cycle result pulse
//           out_data [255]      out - registered result, held until next result/reset
//           busy                out - high while a multiplication is running
module mod_mul
  import ecc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [ECC_W-1:0] opA,
  input  logic [ECC_W-1:0] opB,
  input  logic [ECC_W-1:0] opM,
  output logic             out_valid,
  output logic [ECC_W-1:0] out_data,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [ECC_W-1:0] r_q, r_d;
  logic [ECC_W-1:0] a_q, a_d;
  logic [ECC_W-1:0] b_q, b_d;
  logic [ECC_W-1:0] m_q, m_d;
  logic [ECC_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [ECC_W-1:0] r_next;

  mod_mul_step u_step (
    .r_in  (r_q),
    .b_in  (b_q),
    .m_in  (m_q),
    .a_bit (a_q[cnt_q]),
    .r_out (r_next)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == 8'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      r_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      a_q         <= a_d;
      b_q         <= b_d;
      m_q         <= m_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Datapath next values; in_valid during RUN is deliberately ignored
  always_comb begin
    cnt_d       = cnt_q;
    r_d         = r_q;
    a_d         = a_q;
    b_d         = b_q;
    m_d         = m_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = opA;
          b_d   = opB;
          m_d   = opM;
          r_d   = '0;
          cnt_d = 8'd255;
        end
      end
      RUN: begin
        r_d = r_next;
        if (cnt_q == 8'd0) begin
          out_data_d  = r_next;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q == RUN);
    out_valid = out_valid_q;
    out_data  = out_data_q;
  end

endmodule

// File: doc/mod_mul.md
MOD_MUL -- requirements
Module: mod_mul

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: one-cycle start pulse; operands are valid only in that cycle.
REQ-004 SHALL have port opA, input, 256 bits: multiplicand, required < opM.
REQ-005 SHALL have port opB, input, 256 bits: multiplier, required < opM; in the ECC datapath this is typically the modular-inverse output.
REQ-006 SHALL have port opM, input, 256 bits: modulus.
REQ-007 SHALL have port out_valid, output, 1 bit: one-cycle result pulse.
REQ-008 SHALL have port out_data, output, 256 bits: (opA*opB) mod opM; holds its value until the next result or reset.
REQ-009 SHALL have port busy, output, 1 bit: high while a multiplication is in progress.

Function
REQ-010 SHALL compute (opA*opB) mod opM by MSB-first interleaved shift-add: R=0; for i=255 down to 0: R=2R mod M, then if opA[i]=1, R=(R+opB) mod M.
REQ-011 SHALL perform exactly one iteration per clock, each with two conditional subtractions, using 258-bit internal intermediates so no overflow occurs for any opM up to 2^256-1.
REQ-012 SHALL use two states, IDLE and RUN, plus an 8-bit bit counter.
REQ-013 IDLE: in_valid=1 at rising edge k SHALL latch opA, opB and opM, clear R, set the counter to 255 and enter RUN.
REQ-014 RUN: edges k+1 through k+256 SHALL process bits 255 through 0.
REQ-015 RUN: at edge k+256 the state SHALL return to IDLE, out_data SHALL be loaded with the final R, and out_valid SHALL be set.
REQ-016 Latency SHALL be 256 clocks, from the accepting edge to the edge that raises out_valid.
REQ-017 out_valid SHALL stay high for exactly one cycle; it is cleared at the following edge.
REQ-018 busy SHALL be high from edge k+1 through edge k+256 and low otherwise.
REQ-019 in_valid asserted while busy=1 SHALL be ignored: no latch, no disturbance of the current operation, no extra out_valid.
REQ-020 in_valid asserted in the cycle where out_valid=1 SHALL be accepted, because the state is IDLE; this gives back-to-back throughput of one result per 257 cycles.
REQ-021 opM=1 SHALL naturally yield out_data=0.
REQ-022 opM=0 SHALL yield out_data=0 with normal latency and timing.
REQ-023 Operands violating opA<opM or opB<opM SHALL still complete with normal timing; the result value is then unspecified.
REQ-024 out_data SHALL be a registered output; no combinational path from any input to any output.

Reset
REQ-025 rst=1 SHALL asynchronously force: state=IDLE, counter=0, R=0, out_valid=0, busy=0, out_data=0.
REQ-026 rst asserted mid-operation SHALL abort the operation; no out_valid is produced for it.
REQ-027 After rst is released, the first in_valid sampled at a rising edge SHALL be accepted normally.

Structure
REQ-028 Shared package ecc_pkg SHALL hold the width constant ECC_W=256 and the state enumeration {IDLE, RUN}.
REQ-029 The single iteration SHALL be a combinational sub-module mod_mul_step with inputs R, opB, opM and the current opA bit, and output next R.
REQ-030 mod_mul SHALL contain the FSM, the counter and the operand registers.

Verification
REQ-031 A=3, B=5, M=7 -> out_data=1; out_valid exactly 256 cycles after the accepting edge, high for one cycle.
REQ-032 A=0, B=5, M=7 -> 0; A=6, B=6, M=7 -> 1; M=1 -> 0; M=0 -> 0.
REQ-033 M=P-256 prime FFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF, A=2, B=7FFFFFFF80000000800000000000000000000000800000000000000000000000 -> out_data=1.
REQ-034 500 random triples with A,B<M, compared against a golden-file model in the same format as the mod-inverse bench (three hex lines per pattern: operand, operand, expected) -> all match.
REQ-035 Start pulses at cycles +10 and +100 after an accepted start -> both ignored, single result; then a start in the out_valid cycle -> accepted, second result 256 cycles later.
REQ-036 rst pulse at cycle 128 of a run -> out_valid never rises for that run, outputs zeroed; next start gives the correct result.
